decoder_2to4: RTL and testbench

Registered 2-to-4 line decoder with a synchronous enable. It converts a 2-bit select, formed from inputs `a` (MSB) and `b` (LSB), into one-hot outputs `d1`..`d4`. It sits in front of select/strobe fan-out logic, where glitch-free registered enables are required.

---
 rtl/decoder_2to4_pkg.sv | 29 ++
 rtl/decoder_2to4_core.sv | 25 ++
 rtl/decoder_2to4.sv | 88 ++++++++
 tb/tb_decoder_2to4.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/decoder_2to4_pkg.sv
// Shared types and constants for the registered 2-to-4 decoder.
// Used by decoder_2to4_core and decoder_2to4.
package decoder_2to4_pkg;

  // Select codes formed as {a,b}
  typedef logic [1:0] sel_t;

  // One-hot line vector: bit 0 = d1 ... bit 3 = d4
  typedef logic [3:0] onehot_t;

  localparam sel_t SEL_D1 = 2'b00;
  localparam sel_t SEL_D2 = 2'b01;
  localparam sel_t SEL_D3 = 2'b10;
  localparam sel_t SEL_D4 = 2'b11;

  // Active-high idle pattern (no line asserted)
  localparam onehot_t ONEHOT_IDLE = 4'b0000;

  // True when exactly one bit of the vector is set
  function automatic logic is_onehot(input onehot_t v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return (cnt == 3'd1);
  endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Purely combinational select+enable to active-high one-hot decode.
// Polarity, registering and checking live in the top level.
module decoder_2to4_core
  import decoder_2to4_pkg::*;
(
  input  logic    i_en,
  input  sel_t    i_sel,
  output onehot_t o_onehot
);

  // Decode the select code; all lines idle while disabled
  always_comb begin
    o_onehot = ONEHOT_IDLE;
    if (i_en) begin
      unique case (i_sel)
        SEL_D1:  o_onehot = 4'b0001;
        SEL_D2:  o_onehot = 4'b0010;
        SEL_D3:  o_onehot = 4'b0100;
        SEL_D4:  o_onehot = 4'b1000;
        default: o_onehot = ONEHOT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 line decoder with synchronous enable and optional
// output polarity inversion. All outputs come straight from flops.
// Optional feature macro: DECODER_2TO4_ONEHOT_CHK_EN adds the sticky
// onehot_err output and a one-hot checker on the registered outputs.
module decoder_2to4
  import decoder_2to4_pkg::*;
#(
  parameter logic OUT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
  ,
  output logic onehot_err
`endif
);

  // XOR mask applied after decode; it is also the inactive output pattern
  localparam onehot_t POL_MASK = OUT_ACTIVE_LOW ? onehot_t'(4'hF) : onehot_t'(4'h0);

  sel_t    w_sel_p0;
  onehot_t w_onehot_p0;
  onehot_t w_dout_p0;
  onehot_t r_dout_p1;

  assign w_sel_p0 = {a, b};

  decoder_2to4_core u_core (
    .i_en     (en),
    .i_sel    (w_sel_p0),
    .o_onehot (w_onehot_p0)
  );

  assign w_dout_p0 = w_onehot_p0 ^ POL_MASK;

  // ---- p0 -> p1: output register, reset forces the inactive pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_p1 <= POL_MASK;
    end else begin
      r_dout_p1 <= w_dout_p0;
    end
  end

  assign d1 = r_dout_p1[0];
  assign d2 = r_dout_p1[1];
  assign d3 = r_dout_p1[2];
  assign d4 = r_dout_p1[3];

`ifdef DECODER_2TO4_ONEHOT_CHK_EN
  logic    r_vld_p1;
  logic    r_onehot_err_p2;
  onehot_t w_norm_p1;
  logic    w_viol_p1;

  // Enable aligned with the output register, so the checker knows
  // whether the current outputs should be one-hot or idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= en;
    end
  end

  assign w_norm_p1 = r_dout_p1 ^ POL_MASK;
  assign w_viol_p1 = r_vld_p1 ? !is_onehot(w_norm_p1) : (w_norm_p1 != ONEHOT_IDLE);

  // ---- p1 -> p2: sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_onehot_err_p2 <= 1'b0;
    end else if (w_viol_p1) begin
      r_onehot_err_p2 <= 1'b1;
    end
  end

  assign onehot_err = r_onehot_err_p2;
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4: directed steps followed by random
// stimulus, checked against a behavioural model on an active-high and an
// active-low instance driven by the same inputs.
module tb_decoder_2to4;

  logic clk = 1'b0;
  logic rst, en, a, b;
  logic h1, h2, h3, h4;
  logic l1, l2, l3, l4;
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
  logic herr, lerr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .d1(h1), .d2(h2), .d3(h3), .d4(h4)
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
    , .onehot_err(herr)
`endif
  );

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .d1(l1), .d2(l2), .d3(l3), .d4(l4)
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
    , .onehot_err(lerr)
`endif
  );

  // Reference: the line numbered by the select value is high when enabled
  function automatic logic [3:0] model(input logic r, input logic e,
                                       input logic aa, input logic bb);
    int idx;
    if (r || !e) return 4'b0000;
    idx = 2 * int'(aa) + int'(bb);
    return 4'(1 << idx);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, then check both instances against the model
  task automatic step(input string tag, input logic r, input logic e,
                      input logic aa, input logic bb);
    logic [3:0] exp;
    rst = r; en = e; a = aa; b = bb;
    @(posedge clk);
    #1;
    exp = model(r, e, aa, bb);
    chk({tag, "_hi"}, {h4, h3, h2, h1}, exp);
    chk({tag, "_lo"}, {l4, l3, l2, l1}, ~exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] held;
    rst = 1'b1; en = 1'b1; a = 1'b1; b = 1'b1;

    // Reset held two cycles with all inputs active
    step("rst0", 1'b1, 1'b1, 1'b1, 1'b1);
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
    chk("rst_err", {2'b00, herr, lerr}, 4'b0000);
`endif

    // Full sweep 00, 11, 01, 10
    step("sweep00", 1'b0, 1'b1, 1'b0, 1'b0);
    step("sweep11", 1'b0, 1'b1, 1'b1, 1'b1);
    step("sweep01", 1'b0, 1'b1, 1'b0, 1'b1);
    step("sweep10", 1'b0, 1'b1, 1'b1, 1'b0);

    // Enable gating
    step("en_off", 1'b0, 1'b0, 1'b1, 1'b0);
    step("en_on", 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-stream while d4 is asserted
    step("pre_rst", 1'b0, 1'b1, 1'b1, 1'b1);
    step("mid_rst", 1'b1, 1'b1, 1'b1, 1'b1);
    step("post_rst", 1'b0, 1'b1, 1'b1, 1'b1);

    // Active-low d2 pattern and no combinational path from inputs
    step("sel01", 1'b0, 1'b1, 1'b0, 1'b1);
    held = {h4, h3, h2, h1};
    a = 1'b1; b = 1'b0; en = 1'b0;
    #2;
    chk("hold_hi", {h4, h3, h2, h1}, 4'b0010);
    chk("hold_lo", {l4, l3, l2, l1}, 4'b1101);

    // Unchanged inputs hold the outputs
    step("same0", 1'b0, 1'b1, 1'b0, 1'b0);
    step("same1", 1'b0, 1'b1, 1'b0, 1'b0);

    // Random stimulus with occasional reset
    for (int i = 0; i < 1000; i++) begin
      logic r, e, aa, bb;
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      aa = 1'($urandom_range(0, 1));
      bb = 1'($urandom_range(0, 1));
      step("rand", r, e, aa, bb);
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
      chk("rand_err", {2'b00, herr, lerr}, 4'b0000);
`endif
    end

`ifdef DECODER_2TO4_ONEHOT_CHK_EN
    // Inject a two-hot output register and confirm the sticky flag
    step("inj_pre", 1'b0, 1'b1, 1'b0, 1'b0);
    force dut_hi.r_dout_p1 = 4'b0011;
    @(posedge clk);
    #1;
    release dut_hi.r_dout_p1;
    chk("inj_err", {3'b000, herr}, 4'b0001);
    step("inj_hold0", 1'b0, 1'b1, 1'b1, 1'b0);
    step("inj_hold1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("inj_sticky", {3'b000, herr}, 4'b0001);
    step("inj_clr", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("inj_cleared", {2'b00, herr, lerr}, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
